display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning clock cycles per digit slot; legal range 4..2^20.
REQ-002 SHALL have parameter BLANK, default 2, meaning dead cycles at the start of each slot; legal range 1..DIV-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port en  input  1  scan enable; 0 forces the display off.
REQ-006 SHALL have port digits  input  16  four hex nibbles; digit k = digits[4k+3:4k].
REQ-007 SHALL have port dp_in  input  4  decimal-point bits; bit k belongs to digit k.
REQ-008 SHALL have port sel  output  2  digit index; drives the downstream 2-to-4 decoder select.
REQ-009 SHALL have port sel_en  output  1  active-high enable for the downstream 2-to-4 decoder.
REQ-010 SHALL have port nibble  output  4  hex value of the digit currently selected.
REQ-011 SHALL have port dp  output  1  decimal point of the digit currently selected.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse at the start of each 4-digit frame.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 FSM states SHALL be OFF, BLANK and SHOW, with slot counter cnt running 0..DIV-1 and index sel running 0..3.
REQ-015 OFF: cnt=0, sel=0, sel_en=0, nibble=0, dp=0, frame_start=0.
REQ-016 OFF with en=1 at an edge SHALL give, at that edge: state<=BLANK, cnt<=0, sel<=0, shadow<=digits/dp_in, frame_start<=1.
REQ-017 BLANK/SHOW: cnt SHALL increment by 1 per cycle.
REQ-018 BLANK SHALL go to SHOW on the edge where cnt==BLANK-1.
REQ-019 SHOW SHALL go to BLANK on the edge where cnt==DIV-1; at that edge cnt<=0 and sel<=sel+1 mod 4 (3 wraps to 0).
REQ-020 On the edge where sel wraps 3->0: shadow<=digits/dp_in and frame_start<=1; frame_start SHALL be 0 in all other cycles.
REQ-021 sel_en SHALL be 1 only in SHOW; per slot it is low for exactly BLANK cycles, then high for exactly DIV-BLANK cycles.
REQ-022 nibble/dp SHALL equal shadow entry [sel] in BLANK and SHOW; a change on digits/dp_in mid-frame SHALL NOT appear before the next frame start.
REQ-023 sel and nibble SHALL change only at slot boundaries, while sel_en is 0 (anti-ghosting).
REQ-024 en=0 sampled at any edge in BLANK/SHOW SHALL return the block to OFF with OFF output values on the next cycle; an in-progress slot is abandoned, not finished.
REQ-025 en re-asserted after OFF SHALL always restart at digit 0 with a fresh snapshot (REQ-016).
REQ-026 Frame period SHALL be exactly 4*DIV cycles while en stays 1.

Reset
REQ-027 rst_n=0 sampled at an edge SHALL force state OFF, cnt=0, sel=0, shadow=0, and all outputs 0, overriding en.
REQ-028 Reset asserted mid-slot SHALL take effect at the next edge with no partial-slot completion.
REQ-029 After rst_n returns to 1, behaviour SHALL follow REQ-016 based on en alone.

Verification (DIV=8, BLANK=2)
REQ-030 rst_n=0 for 3 cycles with en=1 -> sel=0, sel_en=0, nibble=0, dp=0, frame_start=0 throughout.
REQ-031 Release reset, en=1, digits=16'h1234, dp_in=4'b0010 -> frame_start high 1 cycle; sel=0, nibble=4, dp=0; sel_en low 2 cycles then high 6; then sel=1, nibble=3, dp=1.
REQ-032 Run 40 cycles -> sel sequence 0,1,2,3,0 at 8-cycle spacing; frame_start pulses exactly 32 cycles apart; nibble values 4,3,2,1,4.
REQ-033 Set digits=16'hABCD while sel=1 -> nibble continues 2,1 for digits 2 and 3; then A..D appear as D,C,B,A starting at the next frame_start.
REQ-034 Drop en at cnt=5 of slot 2 -> next cycle sel=0, sel_en=0, nibble=0; re-raise en -> restart at sel=0 with frame_start pulse.
REQ-035 Pulse rst_n=0 for 1 cycle during SHOW of slot 3 -> all outputs 0 next cycle; with en held 1, scan restarts at digit 0 one cycle after release.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit 7-segment display. It walks
// a digit index through 0..3 and spends DIV clock cycles on each digit. Every
// slot begins with BLANK dead cycles, during which the downstream decoder is
// disabled, so that select and data lines can settle without ghosting. After
// that the decoder is enabled for the rest of the slot. The four digits and
// their decimal points are captured once per frame into a shadow copy, so a
// mid-frame update of the inputs never tears a frame.
//
// Parameters
//   DIV         clock cycles per digit slot (4 .. 2**20)
//   BLANK       dead cycles at the start of each slot (1 .. DIV-1)
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       synchronous active-low reset
//   en          scan enable; 0 turns the display off
//   digits      four hex nibbles, digit k = digits[4k+3:4k]
//   dp_in       decimal-point bits, bit k belongs to digit k
//   sel         digit index driving the downstream 2-to-4 decoder
//   sel_en      active-high enable for the downstream decoder
//   nibble      hex value of the selected digit
//   dp          decimal point of the selected digit
//   frame_start one-cycle pulse at the start of each 4-digit frame
// ---------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int BLANK = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    output logic [1:0]  sel,
    output logic        sel_en,
    output logic [3:0]  nibble,
    output logic        dp,
    output logic        frame_start
);

    localparam int CW = $clog2(DIV);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);

    // The state names carry an ST_ prefix because BLANK is already taken by
    // the dead-time parameter.
    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    sel_nxt;
    logic [15:0]   shadow_dig;
    logic [15:0]   shadow_dig_nxt;
    logic [3:0]    shadow_dp;
    logic [3:0]    shadow_dp_nxt;
    logic          fs_nxt;

    // Next-state logic for the scan sequencer. Dropping en always wins and
    // abandons the current slot. Leaving OFF takes a fresh snapshot and
    // restarts at digit 0. In BLANK and SHOW the slot counter counts up. The
    // hand-over from BLANK to SHOW happens at cnt == BLANK-1. The end of a
    // slot is at cnt == DIV-1, and it advances the digit index. When the
    // index wraps 3 -> 0, a new frame begins: the shadow copy is reloaded and
    // frame_start is pulsed.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        sel_nxt        = sel;
        shadow_dig_nxt = shadow_dig;
        shadow_dp_nxt  = shadow_dp;
        fs_nxt         = 1'b0;
        if (!en) begin
            state_nxt = ST_OFF;
            cnt_nxt   = '0;
            sel_nxt   = 2'd0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_nxt      = ST_BLANK;
                    cnt_nxt        = '0;
                    sel_nxt        = 2'd0;
                    shadow_dig_nxt = digits;
                    shadow_dp_nxt  = dp_in;
                    fs_nxt         = 1'b1;
                end
                ST_BLANK: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == BLANK_LAST) begin
                        state_nxt = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt == DIV_LAST) begin
                        state_nxt = ST_BLANK;
                        cnt_nxt   = '0;
                        sel_nxt   = sel + 2'd1;
                        if (sel == 2'd3) begin
                            shadow_dig_nxt = digits;
                            shadow_dp_nxt  = dp_in;
                            fs_nxt         = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                    sel_nxt   = 2'd0;
                end
            endcase
        end
    end

    // All state and every output are flops. The outputs are loaded from the
    // next-state values, so they line up with the state they describe. The
    // digit data is taken from the next shadow copy, which means the first
    // digit of a new frame shows the freshly captured value. The synchronous
    // reset clears everything, including the shadow copy, and it overrides en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_OFF;
            cnt         <= '0;
            sel         <= 2'd0;
            shadow_dig  <= 16'h0000;
            shadow_dp   <= 4'h0;
            sel_en      <= 1'b0;
            nibble      <= 4'h0;
            dp          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sel         <= sel_nxt;
            shadow_dig  <= shadow_dig_nxt;
            shadow_dp   <= shadow_dp_nxt;
            sel_en      <= (state_nxt == ST_SHOW);
            frame_start <= fs_nxt;
            if (state_nxt == ST_OFF) begin
                nibble <= 4'h0;
                dp     <= 1'b0;
            end else begin
                nibble <= shadow_dig_nxt[{sel_nxt, 2'b00} +: 4];
                dp     <= shadow_dp_nxt[sel_nxt];
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Self-checking bench for display_scan_ctrl with DIV=8, BLANK=2. A reference
// model describes the display in terms of the time elapsed since the current
// frame began and the snapshot taken at that moment. Every negedge, the DUT
// outputs are compared against that model. Directed checkpoints with
// hand-computed values pin both the DUT and the model.
// ---------------------------------------------------------------------------
module tb_display_scan_ctrl;

    localparam int TB_DIV   = 8;
    localparam int TB_BLANK = 2;
    localparam int FRAME    = 4 * TB_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [1:0]  sel;
    logic        sel_en;
    logic [3:0]  nibble;
    logic        dp;
    logic        frame_start;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: whether the display is running, the number of
    // cycles since the first frame started, and the captured snapshot.
    bit          model_valid = 1'b0;
    bit          model_on    = 1'b0;
    int          model_t     = 0;
    logic [15:0] snap_dig    = 16'h0000;
    logic [3:0]  snap_dp     = 4'h0;

    display_scan_ctrl #(
        .DIV   (TB_DIV),
        .BLANK (TB_BLANK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .digits      (digits),
        .dp_in       (dp_in),
        .sel         (sel),
        .sel_en      (sel_en),
        .nibble      (nibble),
        .dp          (dp),
        .frame_start (frame_start)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Advance the reference model at each rising edge, using the inputs
    // sampled at that edge. While running, the position inside a frame is
    // model_t mod FRAME. A new snapshot is taken whenever that position is 0.
    always @(posedge clk) begin
        if (!rst_n) begin
            model_on = 1'b0;
            model_t  = 0;
            snap_dig = 16'h0000;
            snap_dp  = 4'h0;
        end else if (!en) begin
            model_on = 1'b0;
            model_t  = 0;
        end else if (!model_on) begin
            model_on = 1'b1;
            model_t  = 0;
            snap_dig = digits;
            snap_dp  = dp_in;
        end else begin
            model_t = model_t + 1;
            if (model_t % FRAME == 0) begin
                snap_dig = digits;
                snap_dp  = dp_in;
            end
        end
        model_valid = 1'b1;
    end

    // The expected outputs are packed as {sel, sel_en, nibble, dp, frame_start}.
    // They follow from the position within the frame: digit = pos / DIV, and
    // the decoder is enabled once the slot offset reaches BLANK.
    function automatic logic [8:0] modelOut();
        int          p;
        logic [1:0]  s;
        logic [3:0]  nib;
        logic        d;
        if (!model_on) begin
            return 9'd0;
        end
        p   = model_t % FRAME;
        s   = 2'(p / TB_DIV);
        nib = snap_dig[4 * int'(s) +: 4];
        d   = snap_dp[s];
        return {s, ((p % TB_DIV) >= TB_BLANK), nib, d, (p == 0)};
    endfunction

    // Compare the DUT against the model on every falling edge, once the
    // first rising edge has defined the DUT registers.
    always @(negedge clk) begin
        logic [8:0] got;
        logic [8:0] exp;
        if (model_valid) begin
            got = {sel, sel_en, nibble, dp, frame_start};
            exp = modelOut();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL cycle-compare @%0t: got sel=%0d sel_en=%0b nibble=%h dp=%0b fs=%0b, expected sel=%0d sel_en=%0b nibble=%h dp=%0b fs=%0b",
                         $time, got[8:7], got[6], got[5:2], got[1], got[0],
                         exp[8:7], exp[6], exp[5:2], exp[1], exp[0]);
            end
        end
    end

    // Drive all inputs at once. Callers invoke this just after a falling
    // edge, so the values are stable at the next rising edge.
    task automatic applyStimulus(input logic r, input logic e,
                                 input logic [15:0] d, input logic [3:0] p);
        rst_n  = r;
        en     = e;
        digits = d;
        dp_in  = p;
    endtask

    // Move forward n falling edges.
    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Check both the DUT outputs and the model against a hand-computed value.
    task automatic checkOutput(input string name, input logic [1:0] e_sel,
                               input logic e_en, input logic [3:0] e_nib,
                               input logic e_dp, input logic e_fs);
        logic [8:0] exp;
        logic [8:0] got;
        logic [8:0] mdl;
        exp = {e_sel, e_en, e_nib, e_dp, e_fs};
        got = {sel, sel_en, nibble, dp, frame_start};
        mdl = modelOut();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s dut: got sel=%0d sel_en=%0b nibble=%h dp=%0b fs=%0b, expected sel=%0d sel_en=%0b nibble=%h dp=%0b fs=%0b",
                     name, got[8:7], got[6], got[5:2], got[1], got[0],
                     exp[8:7], exp[6], exp[5:2], exp[1], exp[0]);
        end
        vectors++;
        if (mdl !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s model: got %b, expected %b", name, mdl, exp);
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b1, 16'h1234, 4'b0010);

        // Held in reset with en high: every output stays zero.
        for (int i = 0; i < 3; i++) begin
            waitCycles(1);
            checkOutput("reset-hold", 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
        end

        // Release reset. The first frame starts at the next edge.
        applyStimulus(1'b1, 1'b1, 16'h1234, 4'b0010);
        waitCycles(1);
        checkOutput("first-frame-c0", 2'd0, 1'b0, 4'h4, 1'b0, 1'b1);
        waitCycles(1);
        checkOutput("first-frame-c1", 2'd0, 1'b0, 4'h4, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("show-begin-c2", 2'd0, 1'b1, 4'h4, 1'b0, 1'b0);
        waitCycles(5);
        checkOutput("show-end-c7", 2'd0, 1'b1, 4'h4, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("slot1-c8", 2'd1, 1'b0, 4'h3, 1'b1, 1'b0);
        waitCycles(8);
        checkOutput("slot2-c16", 2'd2, 1'b0, 4'h2, 1'b0, 1'b0);
        waitCycles(8);
        checkOutput("slot3-c24", 2'd3, 1'b0, 4'h1, 1'b0, 1'b0);
        waitCycles(8);
        checkOutput("frame2-c32", 2'd0, 1'b0, 4'h4, 1'b0, 1'b1);
        waitCycles(8);
        checkOutput("frame2-slot1", 2'd1, 1'b0, 4'h3, 1'b1, 1'b0);

        // Change the inputs mid-frame. The current frame must not see it.
        applyStimulus(1'b1, 1'b1, 16'hABCD, 4'b1001);
        waitCycles(8);
        checkOutput("stale-slot2", 2'd2, 1'b0, 4'h2, 1'b0, 1'b0);
        waitCycles(8);
        checkOutput("stale-slot3", 2'd3, 1'b0, 4'h1, 1'b0, 1'b0);
        waitCycles(8);
        checkOutput("frame3-slot0", 2'd0, 1'b0, 4'hD, 1'b1, 1'b1);
        waitCycles(8);
        checkOutput("frame3-slot1", 2'd1, 1'b0, 4'hC, 1'b0, 1'b0);
        waitCycles(8);
        checkOutput("frame3-slot2", 2'd2, 1'b0, 4'hB, 1'b0, 1'b0);
        waitCycles(5);
        checkOutput("slot2-cnt5", 2'd2, 1'b1, 4'hB, 1'b0, 1'b0);

        // Drop en at cnt=5 of slot 2. The display is off on the next cycle.
        applyStimulus(1'b1, 1'b0, 16'hABCD, 4'b1001);
        waitCycles(1);
        checkOutput("en-drop", 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
        waitCycles(2);
        checkOutput("en-off-hold", 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);

        // Re-raise en. The scan restarts at digit 0 with a new frame.
        applyStimulus(1'b1, 1'b1, 16'hABCD, 4'b1001);
        waitCycles(1);
        checkOutput("en-restart", 2'd0, 1'b0, 4'hD, 1'b1, 1'b1);
        waitCycles(28);
        checkOutput("slot3-show", 2'd3, 1'b1, 4'hA, 1'b1, 1'b0);

        // One-cycle reset pulse during SHOW of slot 3.
        applyStimulus(1'b0, 1'b1, 16'hABCD, 4'b1001);
        waitCycles(1);
        checkOutput("reset-pulse", 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'hABCD, 4'b1001);
        waitCycles(1);
        checkOutput("post-reset-c0", 2'd0, 1'b0, 4'hD, 1'b1, 1'b1);
        waitCycles(8);
        checkOutput("post-reset-slot1", 2'd1, 1'b0, 4'hC, 1'b0, 1'b0);
        waitCycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
